// File: rtl/btn_evt_ctrl.sv
// btn_evt_ctrl: input conditioning for four push buttons.
// Each raw pad level is synchronized (2 flops), debounced with a per-button
// counter, and turned into a sticky press event. A round-robin arbiter offers
// pending events one at a time over a valid/ready handshake.
//
// Ports:
//   clk        block clock, rising edge
//   rst        synchronous active-high reset
//   btn_core   raw asynchronous button levels (1 = pressed)
//   evt_ready  consumer accepts the offered event
//   ovf_clr    one-cycle pulse clearing all evt_ovf bits
//   btn_level  debounced button levels
//   evt_valid  an event is being offered
//   evt_id     index of the offered button (meaningful while evt_valid)
//   evt_ovf    sticky per-button flag: a press was lost while already pending
module btn_evt_ctrl #(
  parameter int unsigned DEB_CYCLES = 50000,
  parameter int unsigned DEB_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_core,
  input  logic       evt_ready,
  input  logic       ovf_clr,
  output logic [3:0] btn_level,
  output logic       evt_valid,
  output logic [1:0] evt_id,
  output logic [3:0] evt_ovf
);

  typedef enum logic {StIdle, StOffer} state_e;

  localparam logic [DEB_W-1:0] CntMax = DEB_W'(DEB_CYCLES - 1);

  state_e           state_q;
  logic [3:0]       s1_q, s2_q;
  logic [3:0]       pend_q;
  logic [DEB_W-1:0] cnt_q [4];
  logic [1:0]       rr_last_q;

  logic [3:0] cnt_done;
  logic [3:0] press;
  logic [3:0] pend_clr;
  logic [3:0] ovf_set;
  logic       pick_any;
  logic [1:0] pick_id;
  logic [1:0] scan_idx;

  // Press = debounced level about to go 0->1. Clear = accept of the offered id.
  always_comb begin
    cnt_done = '0;
    press    = '0;
    pend_clr = '0;
    for (int i = 0; i < 4; i++) begin
      cnt_done[i] = (cnt_q[i] == CntMax);
      press[i]    = s2_q[i] & ~btn_level[i] & cnt_done[i];
      pend_clr[i] = (state_q == StOffer) && evt_ready && (evt_id == 2'(i));
    end
    // A press that collides with its own accept is not a lost event.
    ovf_set = press & pend_q & ~pend_clr;
  end

  // Round-robin scan starting just after the last served button.
  always_comb begin
    pick_any = 1'b0;
    pick_id  = 2'd0;
    scan_idx = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      scan_idx = rr_last_q + 2'(k);
      if (!pick_any && pend_q[scan_idx]) begin
        pick_any = 1'b1;
        pick_id  = scan_idx;
      end
    end
  end

  // Synchronizer, debounce, pending events and overflow flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      btn_level <= '0;
      pend_q    <= '0;
      evt_ovf   <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q <= btn_core;
      s2_q <= s1_q;
      for (int i = 0; i < 4; i++) begin
        if (s2_q[i] == btn_level[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_done[i]) begin
          btn_level[i] <= s2_q[i];
          cnt_q[i]     <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + DEB_W'(1);
        end
      end
      // Set after clear so a same-edge press keeps the event pending.
      pend_q  <= (pend_q & ~pend_clr) | press;
      // Set wins over ovf_clr.
      evt_ovf <= (ovf_clr ? 4'b0000 : evt_ovf) | ovf_set;
    end
  end

  // Arbiter FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      evt_valid <= 1'b0;
      evt_id    <= 2'd0;
      rr_last_q <= 2'd3;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_any) begin
            evt_id    <= pick_id;
            evt_valid <= 1'b1;
            state_q   <= StOffer;
          end
        end
        StOffer: begin
          if (evt_ready) begin
            rr_last_q <= evt_id;
            evt_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: begin
          evt_valid <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_evt_ctrl.sv
// Testbench for btn_evt_ctrl with DEB_CYCLES = 4. A table of per-cycle
// vectors (inputs plus expected registered outputs after the edge) is built
// up front; each vector's expectation goes to a scoreboard queue when it is
// driven and is popped and compared once the edge has produced the outputs.
module tb_btn_evt_ctrl;

  localparam int unsigned DebCycles = 4;
  localparam int unsigned DebW      = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_core;
  logic       evt_ready;
  logic       ovf_clr;
  logic [3:0] btn_level;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic [3:0] evt_ovf;

  always #5 clk = ~clk;

  btn_evt_ctrl #(
    .DEB_CYCLES(DebCycles),
    .DEB_W     (DebW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_core (btn_core),
    .evt_ready(evt_ready),
    .ovf_clr  (ovf_clr),
    .btn_level(btn_level),
    .evt_valid(evt_valid),
    .evt_id   (evt_id),
    .evt_ovf  (evt_ovf)
  );

  typedef struct {
    logic       rst;
    logic [3:0] btn;
    logic       rdy;
    logic       clr;
    logic [3:0] lvl;
    logic       vld;
    logic [1:0] id;
    logic [3:0] ovf;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic r, input logic [3:0] b, input logic rd, input logic c,
                     input int n, input logic [3:0] l, input logic v, input logic [1:0] i,
                     input logic [3:0] o);
    vec_t e;
    e.rst = r; e.btn = b; e.rdy = rd; e.clr = c;
    e.lvl = l; e.vld = v; e.id = i; e.ovf = o;
    for (int k = 0; k < n; k++) vecs.push_back(e);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    int   n;
    rst = 1'b1; btn_core = 4'h0; evt_ready = 1'b0; ovf_clr = 1'b0;

    // Reset state.
    add(1, 4'h0, 0, 0, 2, 4'h0, 0, 0, 4'h0);
    // Clean press of button 0 with ready high, then release (no event).
    add(0, 4'h1, 1, 0, 5, 4'h0, 0, 0, 4'h0);
    add(0, 4'h1, 1, 0, 1, 4'h1, 0, 0, 4'h0);
    add(0, 4'h1, 1, 0, 1, 4'h1, 1, 0, 4'h0);
    add(0, 4'h1, 1, 0, 3, 4'h1, 0, 0, 4'h0);
    add(0, 4'h0, 1, 0, 5, 4'h1, 0, 0, 4'h0);
    add(0, 4'h0, 1, 0, 2, 4'h0, 0, 0, 4'h0);
    // Glitch of 3 cycles on button 2 is rejected, then a real press.
    add(0, 4'h4, 1, 0, 3, 4'h0, 0, 0, 4'h0);
    add(0, 4'h0, 1, 0, 5, 4'h0, 0, 0, 4'h0);
    add(0, 4'h4, 1, 0, 5, 4'h0, 0, 0, 4'h0);
    add(0, 4'h4, 1, 0, 1, 4'h4, 0, 0, 4'h0);
    add(0, 4'h4, 1, 0, 1, 4'h4, 1, 2, 4'h0);
    add(0, 4'h4, 1, 0, 2, 4'h4, 0, 0, 4'h0);
    add(0, 4'h0, 1, 0, 5, 4'h4, 0, 0, 4'h0);
    add(0, 4'h0, 1, 0, 2, 4'h0, 0, 0, 4'h0);
    // Round-robin: reset restores rr_last = 3, then all four pressed.
    add(1, 4'h0, 1, 0, 1, 4'h0, 0, 0, 4'h0);
    add(0, 4'hF, 1, 0, 5, 4'h0, 0, 0, 4'h0);
    add(0, 4'hF, 1, 0, 1, 4'hF, 0, 0, 4'h0);
    add(0, 4'hF, 1, 0, 1, 4'hF, 1, 0, 4'h0);
    add(0, 4'hF, 1, 0, 1, 4'hF, 0, 0, 4'h0);
    add(0, 4'hF, 1, 0, 1, 4'hF, 1, 1, 4'h0);
    add(0, 4'hF, 1, 0, 1, 4'hF, 0, 0, 4'h0);
    add(0, 4'hF, 1, 0, 1, 4'hF, 1, 2, 4'h0);
    add(0, 4'hF, 1, 0, 1, 4'hF, 0, 0, 4'h0);
    add(0, 4'hF, 1, 0, 1, 4'hF, 1, 3, 4'h0);
    add(0, 4'hF, 1, 0, 2, 4'hF, 0, 0, 4'h0);
    add(0, 4'h0, 1, 0, 5, 4'hF, 0, 0, 4'h0);
    add(0, 4'h0, 1, 0, 2, 4'h0, 0, 0, 4'h0);
    add(0, 4'h2, 1, 0, 5, 4'h0, 0, 0, 4'h0);
    add(0, 4'h2, 1, 0, 1, 4'h2, 0, 0, 4'h0);
    add(0, 4'h2, 1, 0, 1, 4'h2, 1, 1, 4'h0);
    add(0, 4'h2, 1, 0, 2, 4'h2, 0, 0, 4'h0);
    add(0, 4'h0, 1, 0, 5, 4'h2, 0, 0, 4'h0);
    add(0, 4'h0, 1, 0, 2, 4'h0, 0, 0, 4'h0);
    // Backpressure: press/release/press button 3, held offer, overflow, clear.
    add(0, 4'h8, 0, 0, 5, 4'h0, 0, 0, 4'h0);
    add(0, 4'h8, 0, 0, 1, 4'h8, 0, 0, 4'h0);
    add(0, 4'h0, 0, 0, 5, 4'h8, 1, 3, 4'h0);
    add(0, 4'h0, 0, 0, 1, 4'h0, 1, 3, 4'h0);
    add(0, 4'h8, 0, 0, 5, 4'h0, 1, 3, 4'h0);
    add(0, 4'h8, 0, 0, 1, 4'h8, 1, 3, 4'h8);
    add(0, 4'h8, 0, 0, 2, 4'h8, 1, 3, 4'h8);
    add(0, 4'h8, 0, 1, 1, 4'h8, 1, 3, 4'h0);
    add(0, 4'h8, 0, 0, 1, 4'h8, 1, 3, 4'h0);
    add(0, 4'h8, 1, 0, 1, 4'h8, 0, 0, 4'h0);
    add(0, 4'h8, 1, 0, 2, 4'h8, 0, 0, 4'h0);
    add(0, 4'h0, 1, 0, 5, 4'h8, 0, 0, 4'h0);
    add(0, 4'h0, 1, 0, 2, 4'h0, 0, 0, 4'h0);
    // Accept of id 1 on the same edge as a new press of button 1.
    add(0, 4'h2, 0, 0, 5, 4'h0, 0, 0, 4'h0);
    add(0, 4'h2, 0, 0, 1, 4'h2, 0, 0, 4'h0);
    add(0, 4'h2, 0, 0, 1, 4'h2, 1, 1, 4'h0);
    add(0, 4'h0, 0, 0, 5, 4'h2, 1, 1, 4'h0);
    add(0, 4'h0, 0, 0, 1, 4'h0, 1, 1, 4'h0);
    add(0, 4'h2, 0, 0, 5, 4'h0, 1, 1, 4'h0);
    add(0, 4'h2, 1, 0, 1, 4'h2, 0, 0, 4'h0);
    add(0, 4'h2, 1, 0, 1, 4'h2, 1, 1, 4'h0);
    add(0, 4'h2, 1, 0, 2, 4'h2, 0, 0, 4'h0);
    add(0, 4'h0, 1, 0, 5, 4'h2, 0, 0, 4'h0);
    add(0, 4'h0, 1, 0, 2, 4'h0, 0, 0, 4'h0);
    // Reset during an offer with button 0 held, then re-detection.
    add(0, 4'h1, 0, 0, 5, 4'h0, 0, 0, 4'h0);
    add(0, 4'h1, 0, 0, 1, 4'h1, 0, 0, 4'h0);
    add(0, 4'h1, 0, 0, 1, 4'h1, 1, 0, 4'h0);
    add(1, 4'h1, 0, 0, 1, 4'h0, 0, 0, 4'h0);
    add(0, 4'h1, 1, 0, 5, 4'h0, 0, 0, 4'h0);
    add(0, 4'h1, 1, 0, 1, 4'h1, 0, 0, 4'h0);
    add(0, 4'h1, 1, 0, 1, 4'h1, 1, 0, 4'h0);
    add(0, 4'h1, 1, 0, 2, 4'h1, 0, 0, 4'h0);

    for (int v = 0; v < vecs.size(); v++) begin
      @(negedge clk);
      rst       = vecs[v].rst;
      btn_core  = vecs[v].btn;
      evt_ready = vecs[v].rdy;
      ovf_clr   = vecs[v].clr;
      sb.push_back(vecs[v]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("vec%0d btn_level", v), btn_level, e.lvl);
      chk($sformatf("vec%0d evt_valid", v), {3'b000, evt_valid}, {3'b000, e.vld});
      chk($sformatf("vec%0d evt_ovf", v), evt_ovf, e.ovf);
      if (e.vld || e.rst) begin
        chk($sformatf("vec%0d evt_id", v), {2'b00, evt_id}, {2'b00, e.id});
      end
    end

    // Latency of a fresh press of button 2 while button 0 stays held.
    @(negedge clk);
    btn_core  = 4'h5;
    evt_ready = 1'b0;
    n = -1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (evt_valid) begin
        n = k;
        break;
      end
    end
    chk("press2 latency", 4'(n), 4'd6);
    chk("press2 evt_id", {2'b00, evt_id}, 4'd2);
    chk("press2 btn_level", btn_level, 4'h5);
    @(negedge clk);
    evt_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("press2 accepted", {3'b000, evt_valid}, 4'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("press2 no repeat", {3'b000, evt_valid}, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
